// File: rtl/bus_arbiter_if.sv
// Arbitration and shared-bus strobe signals for bus_arbiter.
// master = arbiter side (drives grants and strobes), slave = requester/bus side.
interface bus_arbiter_if;
  logic [3:0] request;
  logic [3:0] grant;
  logic       begin_transaction_in;
  logic       end_transaction_in;
  logic       end_transaction_out;
  logic       bus_error_out;
  logic       bus_busy;
  logic [1:0] owner;

  modport master (
    input  request, begin_transaction_in, end_transaction_in,
    output grant, end_transaction_out, bus_error_out, bus_busy, owner
  );

  modport slave (
    output request, begin_transaction_in, end_transaction_in,
    input  grant, end_transaction_out, bus_error_out, bus_busy, owner
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master round-robin shared-bus arbiter with begin-timeout and optional
// ownership watchdog (enable with macro BUS_ARBITER_OWN_TIMEOUT_EN).
module bus_arbiter #(
  parameter int unsigned BEGIN_TIMEOUT = 16,
  parameter int unsigned OWN_TIMEOUT   = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    WAIT_BEGIN = 2'd2,
    OWNED      = 2'd3
  } state_e;

  localparam logic [10:0] CNT_MAX    = '1;
  localparam logic [10:0] BEGIN_LAST = 11'(BEGIN_TIMEOUT - 1);
  localparam logic [10:0] OWN_LAST   = 11'(OWN_TIMEOUT - 1);

`ifdef BUS_ARBITER_OWN_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  // Watchdog disabled: strobe register has a constant-0 input and folds away.
  localparam bit WDOG_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic [10:0] cnt_q,   cnt_d;
  logic        strobe_q, strobe_d;
  logic [1:0]  winner;

  // Scan from lowest to highest priority so the last hit (owner+1 side) wins.
  always_comb begin
    winner = owner_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus.request[owner_q + 2'(k) + 2'd1]) begin
        winner = owner_q + 2'(k) + 2'd1;
      end
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a variable unassigned and infer a latch.
    state_d  = state_q;
    grant_d  = '0;
    owner_d  = owner_q;
    strobe_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.request) begin
          state_d = GRANT;
          grant_d = 4'b0001 << winner;
          owner_d = winner;
        end
      end
      GRANT: state_d = WAIT_BEGIN;
      WAIT_BEGIN: begin
        if (bus.begin_transaction_in) begin
          state_d = OWNED;
        end else if (cnt_q >= BEGIN_LAST) begin
          state_d = IDLE;
        end
      end
      OWNED: begin
        if (bus.end_transaction_in) begin
          state_d = IDLE;
        end else if (WDOG_EN && cnt_q >= OWN_LAST) begin
          state_d  = IDLE;
          strobe_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 11'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= 2'd3;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.grant               = grant_q;
  assign bus.owner               = owner_q;
  assign bus.bus_busy            = (state_q != IDLE);
  assign bus.end_transaction_out = strobe_q;
  assign bus.bus_error_out       = strobe_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: constant vector table, hand-written timeout/reset
// sequences, and a randomized run against a transaction-level model.
module tb_bus_arbiter;

  localparam int BEGIN_TO = 16;
  localparam int OWN_TO   = 8;
`ifdef BUS_ARBITER_OWN_TIMEOUT_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if bus ();

  bus_arbiter #(
    .BEGIN_TIMEOUT(BEGIN_TO),
    .OWN_TIMEOUT  (OWN_TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: who is granted, waiting, or owning, and for how long.
  int         m_owner;
  logic [3:0] m_grant;
  bit         m_granting, m_waiting, m_owning, m_strobe;
  int         m_wait_cnt, m_own_cnt;

  task automatic model_reset();
    m_owner    = 3;
    m_grant    = '0;
    m_granting = 0;
    m_waiting  = 0;
    m_owning   = 0;
    m_strobe   = 0;
    m_wait_cnt = 0;
    m_own_cnt  = 0;
  endtask

  task automatic model_edge(input logic [3:0] req, input logic b, input logic e);
    int winner;
    bit found;
    m_grant  = '0;
    m_strobe = 0;
    if (m_granting) begin
      m_granting = 0;
      m_waiting  = 1;
      m_wait_cnt = 0;
    end else if (m_waiting) begin
      if (b) begin
        m_waiting = 0;
        m_owning  = 1;
        m_own_cnt = 0;
      end else begin
        m_wait_cnt++;
        if (m_wait_cnt == BEGIN_TO) m_waiting = 0;
      end
    end else if (m_owning) begin
      if (e) begin
        m_owning = 0;
      end else begin
        m_own_cnt++;
        if (WDOG && m_own_cnt == OWN_TO) begin
          m_owning = 0;
          m_strobe = 1;
        end
      end
    end else if (req != 4'b0000) begin
      found  = 0;
      winner = 0;
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (m_owner + k) % 4;
        if (!found && req[idx]) begin
          winner = idx;
          found  = 1;
        end
      end
      m_owner    = winner;
      m_grant    = 4'b0001 << winner;
      m_granting = 1;
    end
  endtask

  task automatic compare_model();
    check("model_grant",   bus.grant, m_grant);
    check("model_busy",    bus.bus_busy, m_granting | m_waiting | m_owning);
    check("model_owner",   bus.owner, m_owner);
    check("model_end_out", bus.end_transaction_out, m_strobe);
    check("model_err_out", bus.bus_error_out, m_strobe);
  endtask

  // Called at a falling edge: drive, clock once, update model, sample at next falling edge.
  task automatic step(input logic [3:0] req, input logic b, input logic e);
    bus.request              = req;
    bus.begin_transaction_in = b;
    bus.end_transaction_in   = e;
    @(posedge clk);
    model_edge(req, b, e);
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},   bus.grant, 4'b0000);
    check({tag, "_busy"},    bus.bus_busy, 1'b0);
    check({tag, "_owner"},   bus.owner, 2'd3);
    check({tag, "_end_out"}, bus.end_transaction_out, 1'b0);
    check({tag, "_err_out"}, bus.bus_error_out, 1'b0);
  endtask

  // Assert reset a few ns into the low phase, check before any rising edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       b;
    logic       e;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  vec_t vecs[28];

  initial begin
    vecs[0]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[2]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[4]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1};
    vecs[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1};
    vecs[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1};
    vecs[10] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1};
    vecs[11] = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[12] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[13] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2};
    vecs[14] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2};
    vecs[15] = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[16] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[17] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[18] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3};
    vecs[19] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[20] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[21] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[22] = '{4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[23] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[24] = '{4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[25] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[26] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[27] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3};

    rst                      = 1'b1;
    bus.request              = 4'b0000;
    bus.begin_transaction_in = 1'b0;
    bus.end_transaction_in   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Vector table: first grant, round-robin order, ignored strobes, dropped request.
    for (int i = 0; i < 28; i++) begin
      step(vecs[i].req, vecs[i].b, vecs[i].e);
      check($sformatf("vec%0d_grant", i), bus.grant, vecs[i].grant);
      check($sformatf("vec%0d_busy", i), bus.bus_busy, vecs[i].busy);
      check($sformatf("vec%0d_owner", i), bus.owner, vecs[i].owner);
      check($sformatf("vec%0d_end_out", i), bus.end_transaction_out, 1'b0);
    end

    // Begin timeout: master 2 granted but never begins; master 3 waits.
    step(4'b0100, 1'b0, 1'b0);
    check("bto_grant", bus.grant, 4'b0100);
    for (int k = 1; k <= 17; k++) begin
      step(4'b1000, 1'b0, 1'b0);
      check($sformatf("bto_busy_%0d", k), bus.bus_busy, (k < 17));
      check($sformatf("bto_strobe_%0d", k), bus.end_transaction_out | bus.bus_error_out, 1'b0);
    end
    step(4'b1000, 1'b0, 1'b0);
    check("bto_next_grant", bus.grant, 4'b1000);
    check("bto_next_owner", bus.owner, 2'd3);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);

    // Ownership watchdog: begin, then never end.
    step(4'b0001, 1'b0, 1'b0);
    check("wdog_grant", bus.grant, 4'b0001);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(4'b0000, 1'b0, 1'b0);
      check($sformatf("wdog_end_out_%0d", k), bus.end_transaction_out, WDOG && (k == 8));
      check($sformatf("wdog_err_out_%0d", k), bus.bus_error_out, WDOG && (k == 8));
      check($sformatf("wdog_busy_%0d", k), bus.bus_busy, !(WDOG && (k == 8)));
    end
    step(4'b0000, 1'b0, 1'b0);
    check("wdog_strobe_once", bus.end_transaction_out, 1'b0);
    check("wdog_busy_after", bus.bus_busy, !WDOG);
    step(4'b0000, 1'b0, 1'b1);
    check("wdog_released", bus.bus_busy, 1'b0);

    // Reset during GRANT, then during OWNED.
    step(4'b0100, 1'b0, 1'b0);
    check("rg_grant", bus.grant, 4'b0100);
    async_reset("rst_in_grant");
    step(4'b0010, 1'b0, 1'b0);
    check("rg_after_grant", bus.grant, 4'b0010);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    check("ro_owned_busy", bus.bus_busy, 1'b1);
    async_reset("rst_in_owned");
    step(4'b0010, 1'b0, 1'b0);
    check("ro_after_grant", bus.grant, 4'b0010);
    check("ro_after_owner", bus.owner, 2'd1);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);

    // Randomized traffic against the model; quiet stretches exercise both timeouts.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] req;
      logic       b;
      logic       e;
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      if ((i % 200) >= 150) begin
        b = ($urandom_range(0, 19) == 0);
        e = ($urandom_range(0, 19) == 0);
      end else begin
        b = ($urandom_range(0, 3) == 0);
        e = ($urandom_range(0, 3) == 0);
      end
      step(req, b, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
